genome_loader: RTL and testbench
================================

# genome_loader

Upstream feeder for `cell_array` port S2. Accepts a stream of genome (cell RAM) words from the host-side DMA/FIFO and replays them into S2 as one write per address. Each write is followed by a mandatory clear cycle, because `cell_array` latches `write_en[s2_address]` every clock and only drops it when `s2_write` is low at that same address. After the last word, the block waits a configurable settle time before flagging `done`, so the fitness read-out never samples a half-configured array.

## Interface
Parameters:
- `DIMX`, 64: cell array X dimension; must match `cell_array`.
- `DIMY`, 64: cell array Y dimension; must match `cell_array`.
- `PORT_WIDTH`, 32: S2 data width, one of 32/64/128.
- `S2_ADDRESS_WIDTH`, 9: S2 address width; must satisfy 2^W ≥ WORDS.
- `SETTLE_CYCLES`, 16: idle cycles after the last clear before `done`; 0 allowed.
- Derived localparam `WORDS` = DIMX*DIMY*4/PORT_WIDTH (512 at defaults).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, shared with `cell_array`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- `abort`  in  1  single-cycle pulse; terminates the load cleanly.
- `in_valid`  in  1  genome word available.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  PORT_WIDTH  genome word; word k goes to S2 address k.
- `s2_write`  out  1  to `cell_array.s2_write`.
- `s2_address`  out  S2_ADDRESS_WIDTH  to `cell_array.s2_address`.
- `s2_writedata`  out  PORT_WIDTH  to `cell_array.s2_writedata`.
- `busy`  out  1  high in FETCH/WRITE/CLEAR/SETTLE.
- `done`  out  1  high in DONE.
- `words_loaded`  out  S2_ADDRESS_WIDTH+1  count of completed write+clear pairs in the current or last load.

## Operation
- States: IDLE, FETCH, WRITE, CLEAR, SETTLE, DONE.
- IDLE/DONE + `start`:
  - Zero `s2_address` and `words_loaded`.
  - Go to FETCH.
- FETCH:
  - `in_ready` = 1 (combinational decode of state).
  - On `in_valid` & `in_ready`, register `in_data` into `s2_writedata` and go to WRITE.
  - Otherwise stay in FETCH.
- WRITE:
  - `s2_write` = 1 for exactly one cycle.
  - Unconditionally go to CLEAR.
- CLEAR:
  - `s2_write` = 0 with the address unchanged, which clears `write_en[addr]` inside `cell_array`.
  - Increment `words_loaded`.
  - If the address is WORDS-1: go to SETTLE, loading the counter with SETTLE_CYCLES; go straight to DONE if SETTLE_CYCLES = 0.
  - Otherwise increment the address and go to FETCH.
- SETTLE: decrement the counter; go to DONE when it reaches 1.
- DONE: `done` = 1 until the next `start` or `rst`.
- `abort`:
  - In FETCH or SETTLE: go to IDLE.
  - In WRITE: go to CLEAR first, then IDLE. A `write_en` bit is never left set.
  - In CLEAR: finish the clear, then go to IDLE.
  - In IDLE or DONE: ignored.
  - `done` is never raised after an abort.
- Simultaneous `start` and `abort`: `abort` wins; `start` is ignored.
- `start` while busy: ignored. There is no restart mid-load.
- `in_data` is sampled only on the handshake. `s2_writedata` holds its value through CLEAR and until the next handshake.
- Address is a plain binary counter and never wraps within a load.

## Timing
- Reset values:
  - State IDLE.
  - `s2_write`, `s2_address`, `s2_writedata`, `words_loaded`, `busy`, `done`, `in_ready` all 0.
- `rst` mid-load drops to IDLE immediately. The `cell_array` `write_en` bit may be left stale; the system resets both blocks together.
- All outputs except `in_ready` are registered.
- Throughput: 3 cycles per word with `in_valid` held high.
- With `start` sampled at edge 0 and `in_valid` held high:
  - Word k: FETCH in cycle 3k+1, WRITE in 3k+2, CLEAR in 3k+3.
  - `done` first high in cycle 3·WORDS + SETTLE_CYCLES + 1.
- Each `in_valid` stall adds one FETCH cycle.

## Structure
- Shared package `ga_pkg`:
  - State enum `loader_state_t`.
  - Function `words_per_array(DIMX, DIMY, PORT_WIDTH)`, also reused by `cell_array` instantiation checks.
- One natural sub-module, `settle_timer`: a loadable down-counter with a zero flag, reused later by the output-sampling stage.
- The FSM, address counter and data register stay in `genome_loader`.

## Test plan
Bench parameters: DIMX=8, DIMY=8, PORT_WIDTH=32, S2_ADDRESS_WIDTH=4 (WORDS=8), SETTLE_CYCLES=4.
1. Continuous stream, data 0xA000_0000+k:
   - Exactly 8 `s2_write` pulses; pulse k at address k with data 0xA000_0000+k.
   - Each pulse is followed by a low cycle at the same address.
   - `done` rises in cycle 29; `words_loaded` = 8.
2. `in_valid` low for 5 cycles before word 3:
   - `in_ready` stays high during the stall, with no writes.
   - `done` is delayed by exactly 5 cycles, to cycle 34.
3. `abort` asserted in the WRITE of word 5:
   - The next cycle is CLEAR at address 5, then IDLE.
   - `words_loaded` = 6; `done` stays 0; a subsequent `start` reloads from address 0.
4. `start` pulsed while busy, and `start`+`abort` in the same cycle during FETCH:
   - The first is ignored.
   - The second goes to IDLE with no restart.
5. `rst` in cycle 10 of a load:
   - Next cycle: all outputs 0, state IDLE.
   - `start` then completes a full 8-word load.
6. SETTLE_CYCLES=0 build: `done` rises in cycle 25, the cycle right after the last CLEAR.

Source files
------------

// File: rtl/ga_pkg.sv
// ---------------------------------------------------------------------------
// ga_pkg
// Shared definitions for the genome loading path and cell array checks.
//   loader_state_t  : genome_loader FSM states.
//   words_per_array : number of S2 port words needed to fill a DIMX x DIMY
//                     cell array (4 config bits per cell).
// ---------------------------------------------------------------------------
package ga_pkg;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_FETCH,
        LS_WRITE,
        LS_CLEAR,
        LS_SETTLE,
        LS_DONE
    } loader_state_t;

    function automatic int words_per_array(input int dimx, input int dimy, input int port_width);
        return (dimx * dimy * 4) / port_width;
    endfunction

endpackage

// File: rtl/genome_loader_if.sv
// ---------------------------------------------------------------------------
// genome_loader_if
// Bundles the genome word stream (host side) and the S2 write port
// (cell_array side) driven by genome_loader.
//   in_valid/in_ready/in_data : word stream into the loader.
//   s2_write/s2_address/s2_writedata : write port towards cell_array S2.
// Modports:
//   master : the loader (consumes the stream, drives S2).
//   slave  : the environment (produces the stream, observes S2).
// ---------------------------------------------------------------------------
interface genome_loader_if #(
    parameter int PORT_WIDTH       = 32,
    parameter int S2_ADDRESS_WIDTH = 9
) ();

    logic                        in_valid;
    logic                        in_ready;
    logic [PORT_WIDTH-1:0]       in_data;
    logic                        s2_write;
    logic [S2_ADDRESS_WIDTH-1:0] s2_address;
    logic [PORT_WIDTH-1:0]       s2_writedata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output s2_write,
        output s2_address,
        output s2_writedata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  s2_write,
        input  s2_address,
        input  s2_writedata
    );

endinterface

// File: rtl/settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Loadable down-counter with a zero flag. Decrementing stops at zero.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (count -> 0).
//   load_i       : load load_val_i into the counter (wins over dec_i).
//   load_val_i   : value to load.
//   dec_i        : decrement by one when non-zero.
//   zero_o       : counter currently holds zero.
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/genome_loader.sv
// ---------------------------------------------------------------------------
// genome_loader
// Replays a stream of genome words into cell_array port S2, one write per
// address, each write followed by a clear cycle at the same address so the
// array's latched write_en bit is dropped. After the last word it waits
// SETTLE_CYCLES before raising done.
// Ports:
//   clk, rst      : clock, synchronous active-high reset.
//   start         : pulse, begins a load (only from IDLE or DONE).
//   abort         : pulse, ends the load cleanly (wins over start).
//   bus (master)  : in_valid/in_ready/in_data stream, s2_* write port.
//   busy          : loader in FETCH/WRITE/CLEAR/SETTLE.
//   done          : load finished and settled.
//   words_loaded  : completed write+clear pairs in current/last load.
// All outputs except in_ready are registered.
// ---------------------------------------------------------------------------
module genome_loader
    import ga_pkg::*;
#(
    parameter int DIMX             = 64,
    parameter int DIMY             = 64,
    parameter int PORT_WIDTH       = 32,
    parameter int S2_ADDRESS_WIDTH = 9,
    parameter int SETTLE_CYCLES    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    genome_loader_if.master           bus,
    output logic                      busy,
    output logic                      done,
    output logic [S2_ADDRESS_WIDTH:0] words_loaded
);

    localparam int WORDS = words_per_array(DIMX, DIMY, PORT_WIDTH);
    localparam logic [S2_ADDRESS_WIDTH-1:0] LAST_ADDR = S2_ADDRESS_WIDTH'(WORDS - 1);

    // The timer is loaded with SETTLE_CYCLES-1 and DONE follows the SETTLE
    // cycle in which it reads zero, giving exactly SETTLE_CYCLES SETTLE cycles.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 1) ? SW'(SETTLE_CYCLES - 1) : '0;

    loader_state_t                 state_q, state_d;
    logic [S2_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [PORT_WIDTH-1:0]         data_q, data_d;
    logic [S2_ADDRESS_WIDTH:0]     wl_q, wl_d;
    logic                          abort_q, abort_d;
    logic                          s2_write_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          timer_load;
    logic                          timer_dec;
    logic                          settle_zero;

    settle_timer #(
        .WIDTH (SW)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (timer_dec),
        .zero_o     (settle_zero)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wl_d       = wl_q;
        abort_d    = abort_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;

        case (state_q)
            LS_IDLE, LS_DONE: begin
                if (start && !abort) begin
                    addr_d  = '0;
                    wl_d    = '0;
                    abort_d = 1'b0;
                    state_d = LS_FETCH;
                end
            end
            LS_FETCH: begin
                if (abort) begin
                    state_d = LS_IDLE;
                end else if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    state_d = LS_WRITE;
                end
            end
            LS_WRITE: begin
                // An abort here is remembered so the clear still happens.
                abort_d = abort;
                state_d = LS_CLEAR;
            end
            LS_CLEAR: begin
                wl_d    = wl_q + (S2_ADDRESS_WIDTH + 1)'(1);
                abort_d = 1'b0;
                if (abort || abort_q) begin
                    state_d = LS_IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = LS_DONE;
                    end else begin
                        timer_load = 1'b1;
                        state_d    = LS_SETTLE;
                    end
                end else begin
                    addr_d  = addr_q + S2_ADDRESS_WIDTH'(1);
                    state_d = LS_FETCH;
                end
            end
            LS_SETTLE: begin
                if (abort) begin
                    state_d = LS_IDLE;
                end else if (settle_zero) begin
                    state_d = LS_DONE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            default: begin
                state_d = LS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LS_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wl_q       <= '0;
            abort_q    <= 1'b0;
            s2_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wl_q       <= wl_d;
            abort_q    <= abort_d;
            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            s2_write_q <= (state_d == LS_WRITE);
            busy_q     <= (state_d == LS_FETCH) || (state_d == LS_WRITE) ||
                          (state_d == LS_CLEAR) || (state_d == LS_SETTLE);
            done_q     <= (state_d == LS_DONE);
        end
    end

    assign bus.in_ready     = (state_q == LS_FETCH);
    assign bus.s2_write     = s2_write_q;
    assign bus.s2_address   = addr_q;
    assign bus.s2_writedata = data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign words_loaded     = wl_q;

endmodule

// File: tb/tb_genome_loader.sv
// ---------------------------------------------------------------------------
// tb_genome_loader
// Scoreboard bench for genome_loader (8x8 array, 32-bit port, 8 words).
// dut_a uses SETTLE_CYCLES=4, dut_b uses SETTLE_CYCLES=0.
// ---------------------------------------------------------------------------
module tb_genome_loader;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk;
    logic       rst;
    logic       start_a, abort_a, busy_a, done_a;
    logic       start_b, abort_b, busy_b, done_b;
    logic [4:0] wl_a, wl_b;

    genome_loader_if #(.PORT_WIDTH(32), .S2_ADDRESS_WIDTH(4)) if_a ();
    genome_loader_if #(.PORT_WIDTH(32), .S2_ADDRESS_WIDTH(4)) if_b ();

    genome_loader #(
        .DIMX(8), .DIMY(8), .PORT_WIDTH(32), .S2_ADDRESS_WIDTH(4), .SETTLE_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .bus(if_a),
        .busy(busy_a), .done(done_a), .words_loaded(wl_a)
    );

    genome_loader #(
        .DIMX(8), .DIMY(8), .PORT_WIDTH(32), .S2_ADDRESS_WIDTH(4), .SETTLE_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .bus(if_b),
        .busy(busy_b), .done(done_b), .words_loaded(wl_b)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    int  e0_a  = 0;
    int  e0_b  = 0;
    int  wr_cnt_b = 0;
    wr_t exp_wr[$];
    int  exp_done_a[$];
    int  exp_done_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: S2 writes, clear cycles and done edges of both DUTs.
    initial begin : monitor
        logic        prev_wr_a, prev_done_a, prev_done_b;
        logic [3:0]  prev_addr_a;
        wr_t         e;
        prev_wr_a = 1'b0; prev_done_a = 1'b0; prev_done_b = 1'b0; prev_addr_a = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_wr_a) begin
                    check("clear_low", if_a.s2_write, 0);
                    check("clear_addr", if_a.s2_address, prev_addr_a);
                end
                if (if_a.s2_write) begin
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_write");
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", if_a.s2_address, e.addr);
                        check("wr_data", if_a.s2_writedata, e.data);
                    end
                end
                if (done_a && !prev_done_a) begin
                    if (exp_done_a.size() == 0) begin
                        fail_now("unexpected_done_a");
                    end else begin
                        check("done_cycle_a", cyc - e0_a + 1, exp_done_a.pop_front());
                        check("done_words_a", wl_a, 8);
                    end
                end
                if (if_b.s2_write) wr_cnt_b++;
                if (done_b && !prev_done_b) begin
                    if (exp_done_b.size() == 0) begin
                        fail_now("unexpected_done_b");
                    end else begin
                        check("done_cycle_b", cyc - e0_b + 1, exp_done_b.pop_front());
                    end
                end
            end
            prev_wr_a   = if_a.s2_write;
            prev_addr_a = if_a.s2_address;
            prev_done_a = done_a;
            prev_done_b = done_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        e0_a = cyc;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!if_a.in_ready && n < 30) begin
            tick();
            n++;
        end
        if (!if_a.in_ready) fail_now("in_ready_timeout");
    endtask

    task automatic wait_done_a();
        int n = 0;
        while (!done_a && n < 80) begin
            tick();
            n++;
        end
        if (!done_a) fail_now("done_timeout");
        tick();
    endtask

    // Feeds words first..first+count-1 with data base+k; optional stall of
    // stall_len FETCH cycles before word stall_word. Returns in the WRITE
    // cycle of the last word fed.
    task automatic run_words(input logic [31:0] base, input int first, input int count,
                             input int stall_word, input int stall_len);
        for (int k = first; k < first + count; k++) begin
            exp_wr.push_back('{addr: 4'(k), data: base + 32'(k)});
            if (k == stall_word) begin
                if_a.in_valid = 1'b0;
                wait_ready_a();
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_ready", if_a.in_ready, 1);
                    check("stall_nowrite", if_a.s2_write, 0);
                    tick();
                end
            end
            if_a.in_valid = 1'b1;
            if_a.in_data  = base + 32'(k);
            wait_ready_a();
            tick();
        end
        if_a.in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_data = '0;
        if_b.in_valid = 1'b0; if_b.in_data = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_s2_write", if_a.s2_write, 0);
        check("rst_s2_address", if_a.s2_address, 0);
        check("rst_s2_writedata", if_a.s2_writedata, 0);
        check("rst_words", wl_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_in_ready", if_a.in_ready, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        tick();

        // 1: continuous stream
        exp_done_a.push_back(29);
        start_load_a();
        run_words(32'hA000_0000, 0, 8, -1, 0);
        wait_done_a();
        check("t1_words", wl_a, 8);
        check("t1_pending_writes", exp_wr.size(), 0);

        // 2: 5-cycle stall before word 3
        exp_done_a.push_back(34);
        start_load_a();
        run_words(32'hB000_0000, 0, 8, 3, 5);
        wait_done_a();
        check("t2_words", wl_a, 8);

        // 3: abort in the WRITE of word 5, then reload
        start_load_a();
        run_words(32'hC000_0000, 0, 6, -1, 0);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("t3_clear_busy", busy_a, 1);
        check("t3_clear_write", if_a.s2_write, 0);
        check("t3_clear_addr", if_a.s2_address, 5);
        tick();
        check("t3_idle_busy", busy_a, 0);
        check("t3_idle_done", done_a, 0);
        check("t3_words", wl_a, 6);
        exp_done_a.push_back(29);
        start_load_a();
        run_words(32'hD000_0000, 0, 8, -1, 0);
        wait_done_a();

        // 4: start while busy, then start+abort together in FETCH
        start_load_a();
        run_words(32'hE000_0000, 0, 3, -1, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_words(32'hE000_0000, 3, 2, -1, 0);
        wait_ready_a();
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("t4_idle_ready", if_a.in_ready, 0);
        check("t4_words", wl_a, 5);
        for (int i = 0; i < 3; i++) begin
            check("t4_no_restart", busy_a, 0);
            tick();
        end

        // 5: reset in cycle 10, then a full load
        start_load_a();
        run_words(32'hF000_0000, 0, 3, -1, 0);
        tick();
        tick();
        check("t5_fetch_ready", if_a.in_ready, 1);
        rst = 1'b1;
        tick();
        check("t5_s2_write", if_a.s2_write, 0);
        check("t5_s2_address", if_a.s2_address, 0);
        check("t5_s2_writedata", if_a.s2_writedata, 0);
        check("t5_words", wl_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_done", done_a, 0);
        check("t5_in_ready", if_a.in_ready, 0);
        rst = 1'b0;
        tick();
        exp_done_a.push_back(29);
        start_load_a();
        run_words(32'h1234_0000, 0, 8, -1, 0);
        wait_done_a();

        // 6: SETTLE_CYCLES=0 build
        exp_done_b.push_back(25);
        if_b.in_valid = 1'b1;
        if_b.in_data  = 32'h5A5A_0000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        e0_b = cyc;
        begin
            int n = 0;
            while (!done_b && n < 60) begin
                tick();
                n++;
            end
            if (!done_b) fail_now("done_b_timeout");
        end
        if_b.in_valid = 1'b0;
        tick();
        check("t6_words", wl_b, 8);
        check("t6_write_count", wr_cnt_b, 8);

        tick();
        check("end_pending_writes", exp_wr.size(), 0);
        check("end_pending_done_a", exp_done_a.size(), 0);
        check("end_pending_done_b", exp_done_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
